// File: rtl/serializador_pkg.sv
// Shared types and sizing helpers for the serializador_entrada block.
package serializador_pkg;

   // FSM state encoding, exported on the estado debug port.
   typedef enum logic [1:0] {
      OCIOSO    = 2'd0,
      DESLOCA   = 2'd1,
      INTERVALO = 2'd2
   } estado_t;

   // Gap counter covers GAP values 0..15.
   localparam int unsigned LarguraIntervalo = 4;

   // Bit counter width for a word of the given length (at least one bit).
   function automatic int unsigned largura_bits(input int unsigned largura);
      return (largura > 1) ? $clog2(largura) : 1;
   endfunction

endpackage

// File: rtl/registrador_deslocamento.sv
// Parallel-load shift register; serial_out always shows the next bit to send.
module registrador_deslocamento #(
   parameter int unsigned WIDTH     = 8,
   parameter bit          MSB_FIRST = 1'b1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             carga,
   input  logic             desloca,
   input  logic [WIDTH-1:0] entrada_paralela,
   output logic             saida_serial
);

   logic [WIDTH-1:0] dados_q, dados_d;

   // Load has priority over shift; the vacated end fills with zero.
   always_comb begin
      dados_d = dados_q;
      if (carga) begin
         dados_d = entrada_paralela;
      end else if (desloca) begin
         if (MSB_FIRST) begin
            dados_d = {dados_q[WIDTH-2:0], 1'b0};
         end else begin
            dados_d = {1'b0, dados_q[WIDTH-1:1]};
         end
      end
   end

   // Register with synchronous active-low clear.
   always_ff @(posedge clock) begin
      if (!reset) begin
         dados_q <= '0;
      end else begin
         dados_q <= dados_d;
      end
   end

   // Head of the register is the bit currently on the line.
   always_comb begin
      saida_serial = MSB_FIRST ? dados_q[WIDTH-1] : dados_q[0];
   end

endmodule

// File: rtl/serializador_entrada.sv
// Word-to-bit serializer feeding the SM1 detector, with optional idle gap between words.
module serializador_entrada
   import serializador_pkg::*;
#(
   parameter int unsigned WIDTH      = 8,
   parameter bit          MSB_FIRST  = 1'b1,
   parameter int unsigned GAP        = 0,
   parameter bit          IDLE_LEVEL = 1'b0
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] dado,
   input  logic             dado_valido,
   output logic             pronto,
   output logic             saida_serial,
   output logic             serial_valido,
   output logic [1:0]       estado,
   output logic [15:0]      contagem_palavras
);

   localparam int unsigned LarguraBits = largura_bits(WIDTH);
   localparam logic [LarguraBits-1:0] UltimoBit = LarguraBits'(WIDTH - 1);
   localparam logic [LarguraIntervalo-1:0] UltimoIntervalo =
      LarguraIntervalo'((GAP > 0) ? GAP - 1 : 0);

   estado_t                     estado_q, estado_d;
   logic [LarguraBits-1:0]      bit_q, bit_d;
   logic [LarguraIntervalo-1:0] intervalo_q, intervalo_d;
   logic [15:0]                 contagem_q, contagem_d;
   logic                        ultimo_bit;
   logic                        transferencia;
   logic                        carga;
   logic                        desloca;
   logic                        bit_serial;

   registrador_deslocamento #(
      .WIDTH     (WIDTH),
      .MSB_FIRST (MSB_FIRST)
   ) u_registrador (
      .clock            (clock),
      .reset            (reset),
      .carga            (carga),
      .desloca          (desloca),
      .entrada_paralela (dado),
      .saida_serial     (bit_serial)
   );

   // Handshake: ready when idle, or on the final bit when words may run back-to-back.
   always_comb begin
      ultimo_bit    = (estado_q == DESLOCA) && (bit_q == UltimoBit);
      pronto        = reset && ((estado_q == OCIOSO) || ((GAP == 0) && ultimo_bit));
      transferencia = dado_valido && pronto;
   end

   // State register.
   always_ff @(posedge clock) begin
      if (!reset) begin
         estado_q <= OCIOSO;
      end else begin
         estado_q <= estado_d;
      end
   end

   // Next-state logic; any unused encoding falls back to OCIOSO.
   always_comb begin
      estado_d = estado_q;
      case (estado_q)
         OCIOSO: begin
            if (transferencia) estado_d = DESLOCA;
         end
         DESLOCA: begin
            if (ultimo_bit) begin
               if (GAP > 0)            estado_d = INTERVALO;
               else if (transferencia) estado_d = DESLOCA;
               else                    estado_d = OCIOSO;
            end
         end
         INTERVALO: begin
            if (intervalo_q == UltimoIntervalo) estado_d = OCIOSO;
         end
         default: estado_d = OCIOSO;
      endcase
   end

   // Bit, gap and word counters plus shift-register control.
   always_comb begin
      bit_d       = bit_q;
      intervalo_d = intervalo_q;
      contagem_d  = contagem_q;
      carga       = transferencia;
      desloca     = 1'b0;
      case (estado_q)
         DESLOCA: begin
            if (ultimo_bit) begin
               bit_d       = '0;
               intervalo_d = '0;
               contagem_d  = contagem_q + 16'd1;
            end else begin
               bit_d   = bit_q + 1'b1;
               desloca = 1'b1;
            end
         end
         INTERVALO: begin
            intervalo_d = intervalo_q + 1'b1;
         end
         default: begin
            bit_d       = '0;
            intervalo_d = '0;
         end
      endcase
   end

   // Counter registers; a reset mid-word drops the partial word uncounted.
   always_ff @(posedge clock) begin
      if (!reset) begin
         bit_q       <= '0;
         intervalo_q <= '0;
         contagem_q  <= '0;
      end else begin
         bit_q       <= bit_d;
         intervalo_q <= intervalo_d;
         contagem_q  <= contagem_d;
      end
   end

   // Outputs decoded from registered state only.
   always_comb begin
      serial_valido     = (estado_q == DESLOCA);
      saida_serial      = (estado_q == DESLOCA) ? bit_serial : IDLE_LEVEL;
      estado            = estado_q;
      contagem_palavras = contagem_q;
   end

endmodule

// File: tb/tb_serializador_entrada.sv
// Bench for serializador_entrada: three configurations checked against a queue-based model.
module tb_serializador_entrada;

   logic        clock = 1'b0;
   logic        reset;
   logic [7:0]  dado [3];
   logic        valido [3];
   logic        pronto_w [3];
   logic        ser_w [3];
   logic        sv_w [3];
   logic [1:0]  est_w [3];
   logic [15:0] cont_w [3];

   int erros  = 0;
   int checks = 0;

   // Model: per-instance queue of upcoming line symbols.
   // 0/1 = data bit, 4/5 = last data bit of a word, 8 = gap cycle.
   int          fila [3][$];
   logic [15:0] cont [3];

   always #5 clock = ~clock;

   serializador_entrada #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP(0), .IDLE_LEVEL(1'b0)) d0 (
      .clock (clock), .reset (reset), .dado (dado[0]), .dado_valido (valido[0]),
      .pronto (pronto_w[0]), .saida_serial (ser_w[0]), .serial_valido (sv_w[0]),
      .estado (est_w[0]), .contagem_palavras (cont_w[0])
   );
   serializador_entrada #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP(2), .IDLE_LEVEL(1'b0)) d1 (
      .clock (clock), .reset (reset), .dado (dado[1]), .dado_valido (valido[1]),
      .pronto (pronto_w[1]), .saida_serial (ser_w[1]), .serial_valido (sv_w[1]),
      .estado (est_w[1]), .contagem_palavras (cont_w[1])
   );
   serializador_entrada #(.WIDTH(8), .MSB_FIRST(1'b0), .GAP(1), .IDLE_LEVEL(1'b1)) d2 (
      .clock (clock), .reset (reset), .dado (dado[2]), .dado_valido (valido[2]),
      .pronto (pronto_w[2]), .saida_serial (ser_w[2]), .serial_valido (sv_w[2]),
      .estado (est_w[2]), .contagem_palavras (cont_w[2])
   );

   function automatic int gap_de(int i);
      return (i == 0) ? 0 : ((i == 1) ? 2 : 1);
   endfunction

   function automatic bit msb_de(int i);
      return (i != 2);
   endfunction

   function automatic logic idle_de(int i);
      return (i == 2);
   endfunction

   // Expected {pronto, saida_serial, serial_valido, estado, contagem} for the current cycle.
   function automatic logic [20:0] esperado(int i);
      logic p, s, v;
      logic [1:0] e;
      int tam, f;
      tam = fila[i].size();
      f   = (tam > 0) ? fila[i][0] : -1;
      p   = reset && ((tam == 0) || ((gap_de(i) == 0) && (tam == 1) && (f >= 4) && (f < 8)));
      if (tam == 0) begin
         s = idle_de(i); v = 1'b0; e = 2'd0;
      end else if (f == 8) begin
         s = idle_de(i); v = 1'b0; e = 2'd2;
      end else begin
         s = f[0]; v = 1'b1; e = 2'd1;
      end
      return {p, s, v, e, cont[i]};
   endfunction

   // Queue the line symbols produced by one accepted word.
   task automatic empilha(int i, logic [7:0] w);
      for (int k = 0; k < 8; k++) begin
         int idx;
         int b;
         idx = msb_de(i) ? 7 - k : k;
         b   = int'(w[idx]);
         fila[i].push_back(b + ((k == 7) ? 4 : 0));
      end
      for (int g = 0; g < gap_de(i); g++) fila[i].push_back(8);
   endtask

   // One clock: decide transfers from current inputs, advance the model, settle on negedge.
   task automatic passo();
      bit         tr [3];
      logic [7:0] pal [3];
      for (int i = 0; i < 3; i++) begin
         logic [20:0] ex;
         ex     = esperado(i);
         tr[i]  = reset && valido[i] && ex[20];
         pal[i] = dado[i];
      end
      @(posedge clock);
      for (int i = 0; i < 3; i++) begin
         if (!reset) begin
            fila[i].delete();
            cont[i] = 16'd0;
         end else begin
            if (fila[i].size() > 0) begin
               int s;
               s = fila[i].pop_front();
               if ((s >= 4) && (s < 8)) cont[i] = cont[i] + 16'd1;
            end
            if (tr[i]) empilha(i, pal[i]);
         end
      end
      @(negedge clock);
   endtask

   task automatic test_reset();
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         valido[i] = 1'b1;
         dado[i]   = 8'hFF;
      end
      passo();
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (pronto_w[i] !== 1'b0) begin
            erros++;
            $display("FAIL reset_pronto d%0d: obtido=%b esperado=0", i, pronto_w[i]);
         end
      end
      passo();
      for (int i = 0; i < 3; i++) begin
         logic [20:0] obs, req;
         obs = {pronto_w[i], ser_w[i], sv_w[i], est_w[i], cont_w[i]};
         req = {1'b0, idle_de(i), 1'b0, 2'd0, 16'd0};
         checks++;
         if (obs !== req) begin
            erros++;
            $display("FAIL reset_estado d%0d: obtido=%h esperado=%h", i, obs, req);
         end
      end
      reset = 1'b1;
      for (int i = 0; i < 3; i++) valido[i] = 1'b0;
      passo();
      for (int i = 0; i < 3; i++) begin
         checks++;
         if ({pronto_w[i], est_w[i], sv_w[i]} !== {1'b1, 2'd0, 1'b0}) begin
            erros++;
            $display("FAIL reset_liberado d%0d: obtido=%b%b%b esperado=1000", i,
                     pronto_w[i], est_w[i], sv_w[i]);
         end
      end
   endtask

   task automatic test_palavra_a5();
      logic [7:0] w;
      w = 8'hA5;
      dado[0] = w; valido[0] = 1'b1;
      passo();
      valido[0] = 1'b0;
      for (int k = 0; k < 8; k++) begin
         logic [20:0] obs, ex;
         obs = {pronto_w[0], ser_w[0], sv_w[0], est_w[0], cont_w[0]};
         ex  = esperado(0);
         checks++;
         if (obs !== ex) begin
            erros++;
            $display("FAIL a5_modelo bit %0d: obtido=%h esperado=%h", k, obs, ex);
         end
         checks++;
         if ({ser_w[0], sv_w[0]} !== {w[7-k], 1'b1}) begin
            erros++;
            $display("FAIL a5_bit %0d: obtido=%b%b esperado=%b1", k, ser_w[0], sv_w[0], w[7-k]);
         end
         passo();
      end
      checks++;
      if ({est_w[0], cont_w[0]} !== {2'd0, 16'd1}) begin
         erros++;
         $display("FAIL a5_fim: estado=%0d contagem=%0d esperado 0 e 1", est_w[0], cont_w[0]);
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] seq;
      seq = 16'hF00F;
      dado[0] = 8'hF0; valido[0] = 1'b1;
      passo();
      dado[0] = 8'h0F;
      for (int k = 0; k < 16; k++) begin
         logic [20:0] obs, ex;
         if (k == 8) valido[0] = 1'b0;
         obs = {pronto_w[0], ser_w[0], sv_w[0], est_w[0], cont_w[0]};
         ex  = esperado(0);
         checks++;
         if (obs !== ex) begin
            erros++;
            $display("FAIL b2b_modelo ciclo %0d: obtido=%h esperado=%h", k, obs, ex);
         end
         checks++;
         if ({ser_w[0], sv_w[0]} !== {seq[15-k], 1'b1}) begin
            erros++;
            $display("FAIL b2b_bit %0d: obtido=%b%b esperado=%b1", k, ser_w[0], sv_w[0], seq[15-k]);
         end
         if (k == 7) begin
            checks++;
            if (pronto_w[0] !== 1'b1) begin
               erros++;
               $display("FAIL b2b_pronto_ultimo: obtido=%b esperado=1", pronto_w[0]);
            end
         end
         passo();
      end
      checks++;
      if ({est_w[0], cont_w[0]} !== {2'd0, 16'd3}) begin
         erros++;
         $display("FAIL b2b_fim: estado=%0d contagem=%0d esperado 0 e 3", est_w[0], cont_w[0]);
      end
   endtask

   task automatic test_intervalo();
      logic [7:0] w;
      w = 8'h81;
      dado[1] = w; valido[1] = 1'b1;
      passo();
      for (int k = 0; k < 19; k++) begin
         logic [20:0] obs, ex;
         if (k == 11) valido[1] = 1'b0;
         obs = {pronto_w[1], ser_w[1], sv_w[1], est_w[1], cont_w[1]};
         ex  = esperado(1);
         checks++;
         if (obs !== ex) begin
            erros++;
            $display("FAIL gap_modelo ciclo %0d: obtido=%h esperado=%h", k, obs, ex);
         end
         checks++;
         if (k < 8) begin
            if ({ser_w[1], sv_w[1]} !== {w[7-k], 1'b1}) begin
               erros++;
               $display("FAIL gap_bit1 %0d: obtido=%b%b", k, ser_w[1], sv_w[1]);
            end
         end else if (k < 10) begin
            if ({pronto_w[1], ser_w[1], sv_w[1]} !== 3'b000) begin
               erros++;
               $display("FAIL gap_ocioso %0d: obtido=%b%b%b esperado=000", k,
                        pronto_w[1], ser_w[1], sv_w[1]);
            end
         end else if (k == 10) begin
            if ({pronto_w[1], est_w[1]} !== {1'b1, 2'd0}) begin
               erros++;
               $display("FAIL gap_retorno: pronto=%b estado=%0d esperado 1 e 0",
                        pronto_w[1], est_w[1]);
            end
         end else begin
            if ({ser_w[1], sv_w[1]} !== {w[18-k], 1'b1}) begin
               erros++;
               $display("FAIL gap_bit2 %0d: obtido=%b%b", k, ser_w[1], sv_w[1]);
            end
         end
         passo();
      end
      checks++;
      if (cont_w[1] !== 16'd2) begin
         erros++;
         $display("FAIL gap_contagem: obtido=%0d esperado=2", cont_w[1]);
      end
      for (int k = 0; k < 3; k++) passo();
   endtask

   task automatic test_lsb();
      checks++;
      if (ser_w[2] !== 1'b1) begin
         erros++;
         $display("FAIL lsb_idle: obtido=%b esperado=1", ser_w[2]);
      end
      dado[2] = 8'h01; valido[2] = 1'b1;
      passo();
      valido[2] = 1'b0;
      for (int k = 0; k < 8; k++) begin
         logic [20:0] obs, ex;
         obs = {pronto_w[2], ser_w[2], sv_w[2], est_w[2], cont_w[2]};
         ex  = esperado(2);
         checks++;
         if (obs !== ex) begin
            erros++;
            $display("FAIL lsb_modelo bit %0d: obtido=%h esperado=%h", k, obs, ex);
         end
         checks++;
         if ({ser_w[2], sv_w[2]} !== {(k == 0), 1'b1}) begin
            erros++;
            $display("FAIL lsb_bit %0d: obtido=%b%b", k, ser_w[2], sv_w[2]);
         end
         passo();
      end
      checks++;
      if ({est_w[2], ser_w[2], sv_w[2], pronto_w[2]} !== {2'd2, 1'b1, 1'b0, 1'b0}) begin
         erros++;
         $display("FAIL lsb_intervalo: estado=%0d ser=%b sv=%b pronto=%b", est_w[2],
                  ser_w[2], sv_w[2], pronto_w[2]);
      end
      passo();
      checks++;
      if ({est_w[2], cont_w[2]} !== {2'd0, 16'd1}) begin
         erros++;
         $display("FAIL lsb_fim: estado=%0d contagem=%0d", est_w[2], cont_w[2]);
      end
   endtask

   task automatic test_reset_meio();
      logic [7:0] w;
      dado[0] = 8'hFF; valido[0] = 1'b1;
      passo();
      valido[0] = 1'b0;
      for (int k = 0; k < 3; k++) passo();
      checks++;
      if ({ser_w[0], sv_w[0]} !== 2'b11) begin
         erros++;
         $display("FAIL meio_quarto_bit: obtido=%b%b esperado=11", ser_w[0], sv_w[0]);
      end
      reset = 1'b0;
      passo();
      checks++;
      if ({est_w[0], ser_w[0], sv_w[0], cont_w[0]} !== {2'd0, 1'b0, 1'b0, 16'd0}) begin
         erros++;
         $display("FAIL meio_reset: estado=%0d ser=%b sv=%b contagem=%0d", est_w[0],
                  ser_w[0], sv_w[0], cont_w[0]);
      end
      reset = 1'b1;
      w = 8'h55;
      dado[0] = w; valido[0] = 1'b1;
      passo();
      valido[0] = 1'b0;
      for (int k = 0; k < 8; k++) begin
         checks++;
         if ({ser_w[0], sv_w[0]} !== {w[7-k], 1'b1}) begin
            erros++;
            $display("FAIL meio_55 bit %0d: obtido=%b%b esperado=%b1", k, ser_w[0], sv_w[0],
                     w[7-k]);
         end
         passo();
      end
      checks++;
      if (cont_w[0] !== 16'd1) begin
         erros++;
         $display("FAIL meio_contagem: obtido=%0d esperado=1", cont_w[0]);
      end
   endtask

   task automatic test_aleatorio();
      for (int c = 0; c < 600; c++) begin
         for (int i = 0; i < 3; i++) begin
            dado[i]   = 8'($urandom);
            valido[i] = ($urandom_range(0, 3) != 0);
         end
         reset = ($urandom_range(0, 79) != 0);
         if (c >= 580) begin
            reset = 1'b1;
            for (int i = 0; i < 3; i++) valido[i] = 1'b0;
         end
         passo();
         for (int i = 0; i < 3; i++) begin
            logic [20:0] obs, ex;
            obs = {pronto_w[i], ser_w[i], sv_w[i], est_w[i], cont_w[i]};
            ex  = esperado(i);
            checks++;
            if (obs !== ex) begin
               erros++;
               $display("FAIL aleatorio d%0d ciclo %0d: obtido=%h esperado=%h", i, c, obs, ex);
            end
         end
      end
   endtask

   task automatic test_contagem_volta();
      // Preload the word counter so the wrap is reached without sending 65534 words.
      d0.contagem_q = 16'hFFFE;
      cont[0] = 16'hFFFE;
      passo();
      checks++;
      if (cont_w[0] !== 16'hFFFE) begin
         erros++;
         $display("FAIL volta_pre: obtido=%h esperado=fffe", cont_w[0]);
      end
      dado[0] = 8'h3C; valido[0] = 1'b1;
      passo();
      dado[0] = 8'hC3;
      for (int k = 0; k < 16; k++) begin
         logic [20:0] obs, ex;
         if (k == 8) valido[0] = 1'b0;
         obs = {pronto_w[0], ser_w[0], sv_w[0], est_w[0], cont_w[0]};
         ex  = esperado(0);
         checks++;
         if (obs !== ex) begin
            erros++;
            $display("FAIL volta_modelo ciclo %0d: obtido=%h esperado=%h", k, obs, ex);
         end
         if (k == 8) begin
            checks++;
            if (cont_w[0] !== 16'hFFFF) begin
               erros++;
               $display("FAIL volta_ffff: obtido=%h esperado=ffff", cont_w[0]);
            end
         end
         passo();
      end
      checks++;
      if ({est_w[0], cont_w[0]} !== {2'd0, 16'd0}) begin
         erros++;
         $display("FAIL volta_zero: estado=%0d contagem=%h esperado 0 e 0000", est_w[0],
                  cont_w[0]);
      end
   endtask

   initial begin
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         valido[i] = 1'b0;
         dado[i]   = 8'h00;
         cont[i]   = 16'd0;
      end
      @(negedge clock);
      test_reset();
      test_palavra_a5();
      test_back_to_back();
      test_intervalo();
      test_lsb();
      test_reset_meio();
      test_aleatorio();
      test_contagem_volta();
      $display("Result: errors=%0d of %0d checks", erros, checks);
      $finish;
   end

endmodule
